// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-counter run controller: FSM state encoding
// plus small helpers for terminal-count and bit-population arithmetic.
package gray_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Last code of a reflected W-bit Gray sequence: MSB set, all other bits clear.
   function automatic logic [31:0] gray_tc(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Gray-sequence step checker: after every enabled cycle the counter value must
// differ from the previous one in exactly one bit; the first RUN cycle must read 0.
module gray_step_chk
   import gray_ctrl_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] q,
   input  logic         ce,
   input  logic         run,
   input  logic         first,
   output logic         bad
);

   logic [W-1:0] prev_q;
   logic         prev_ce;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         prev_ce <= 1'b0;
      end else begin
         prev_q  <= q;
         prev_ce <= ce;
      end
   end

   always_comb begin
      bad = 1'b0;
      if (run && prev_ce && (popcount(32'(q ^ prev_q)) != 32'd1)) begin
         bad = 1'b1;
      end
      if (run && first && (q != '0)) begin
         bad = 1'b1;
      end
   end

endmodule

// File: rtl/gray_run_ctrl.sv
// Run controller for an external Gray counter: clears it, enables it for len
// full periods (with pause/abort), counts wraps and flags illegal Gray steps.
module gray_run_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int unsigned W  = 4,
   parameter int unsigned LW = 8
) (
   input  logic          clk,
   input  logic          R_n,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          pause,
   input  logic          abort,
   input  logic [W-1:0]  cnt_q,
   input  logic          cnt_ceo,
   output logic          cnt_ce,
   output logic          cnt_r,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] wraps,
   output logic          err
);

   state_t        state;
   state_t        next_state;
   logic [LW-1:0] len_r;
   logic          first_run;
   logic          accept;
   logic          wrap_inc;
   logic          in_run;
   logic          chk_bad;
   logic [LW:0]   wraps_plus;

   assign wraps_plus = {1'b0, wraps} + {{LW{1'b0}}, 1'b1};
   assign in_run     = (state == ST_RUN);

   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state     <= ST_IDLE;
         len_r     <= '0;
         wraps     <= '0;
         err       <= 1'b0;
         first_run <= 1'b0;
      end else begin
         state     <= next_state;
         first_run <= (state == ST_CLR);
         if (accept) begin
            len_r <= len;
            wraps <= '0;
            err   <= 1'b0;
         end else begin
            if (wrap_inc && (wraps != '1)) begin
               wraps <= wraps_plus[LW-1:0];
            end
            if (chk_bad) begin
               err <= 1'b1;
            end
         end
      end
   end

   // Abort is tested before cnt_ceo so a final wrap never turns an abort into done.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      wrap_inc   = 1'b0;
      cnt_ce     = 1'b0;
      cnt_r      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = (len == '0) ? ST_DONE : ST_CLR;
            end
         end
         ST_CLR: begin
            cnt_r      = 1'b1;
            busy       = 1'b1;
            next_state = abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            busy   = 1'b1;
            cnt_ce = ~pause & ~abort;
            if (abort) begin
               next_state = ST_IDLE;
            end else if (cnt_ceo) begin
               wrap_inc = 1'b1;
               if (wraps_plus == {1'b0, len_r}) begin
                  next_state = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
      endcase
   end

   gray_step_chk #(
      .W(W)
   ) u_chk (
      .clk  (clk),
      .rst_n(R_n),
      .q    (cnt_q),
      .ce   (cnt_ce),
      .run  (in_run),
      .first(first_run),
      .bad  (chk_bad)
   );

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: behavioural Gray counter, table-driven runs,
// hand-written corner sequences and randomized runs against a run-level model.
module tb_gray_run_ctrl;
   import gray_ctrl_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned LW = 8;
   localparam logic [W-1:0] TC = W'(gray_tc(W));

   logic          clk = 1'b0;
   logic          R_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          pause = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  cnt_q;
   logic          cnt_ceo;
   logic          cnt_ce, cnt_r, busy, done, err;
   logic [LW-1:0] wraps;

   logic [W-1:0]  bin;
   logic          inject = 1'b0;
   logic          hold_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   bit pat [512];

   typedef struct {
      int len; int ps; int pl; int ab;
      int e_done; int e_wraps; int e_run; int e_ce;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   // Counter: inject skips one code (2-bit jump), hold_clr ignores the clear.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) bin <= '0;
      else if (cnt_r && !hold_clr) bin <= '0;
      else if (cnt_ce) bin <= bin + (inject ? W'(2) : W'(1));
   end
   assign cnt_q   = bin ^ (bin >> 1);
   assign cnt_ceo = cnt_ce & (cnt_q == TC);

   gray_run_ctrl #(.W(W), .LW(LW)) dut (
      .clk(clk), .R_n(R_n), .start(start), .len(len), .pause(pause), .abort(abort),
      .cnt_q(cnt_q), .cnt_ceo(cnt_ceo), .cnt_ce(cnt_ce), .cnt_r(cnt_r), .busy(busy),
      .done(done), .wraps(wraps), .err(err)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Run-level model: a run needs 16*len enabled cycles; abort ends it early.
   function automatic void model(input int l, input int ab,
                                 output int d, output int w, output int r, output int c);
      int e;
      d = 1; w = 0; r = 0; c = 0;
      if (l == 0) return;
      d = 0;
      if (ab == -2) return;
      e = 0;
      for (int k = 0; k < 4000; k++) begin
         if (k == ab) begin
            d = 0; w = e / 16; r = k + 1; c = e;
            return;
         end
         if (k >= 512 || !pat[k]) e++;
         if (e == 16 * l) begin
            d = 1; w = l; r = k + 1; c = e;
            return;
         end
      end
   endfunction

   task automatic run_one(input string tag, input int l, input int ab, input bit rnd,
                          input int e_done, input int e_wraps, input int e_run, input int e_ce);
      int n_done, n_run, n_ce, cyc, ce_out, frz_bad, q_end;
      logic [W-1:0] last_q;
      bit last_held, idle_seen;
      n_done = 0; n_run = 0; n_ce = 0; cyc = 0; ce_out = 0; frz_bad = 0; q_end = 0;
      last_q = '0; last_held = 1'b0; idle_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; len = LW'(l); pause = 1'b0; abort = 1'b0;
      while (!idle_seen && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         pause = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         abort = 1'b0;
         if (rnd) len = LW'($urandom_range(0, 3));
         if (cnt_r) begin
            if (ab == -2) abort = 1'b1;
            #1 if (cnt_ce) ce_out++;
         end else if (busy) begin
            if (last_held && cnt_q != last_q) frz_bad++;
            pause = (n_run < 512) ? pat[n_run] : 1'b0;
            abort = (n_run == ab);
            #1;
            if (cnt_ce) n_ce++;
            last_held = !cnt_ce;
            last_q = cnt_q;
            n_run++;
         end else if (done) begin
            n_done++;
            q_end = int'(cnt_q);
            #1 if (cnt_ce) ce_out++;
         end else begin
            idle_seen = 1'b1;
            start = 1'b0;
            pause = 1'b0;
            #1 if (cnt_ce) ce_out++;
         end
      end
      if (!idle_seen) check({tag, ".timeout"}, 0, 1);
      check({tag, ".done_pulses"}, n_done, e_done);
      check({tag, ".wraps"}, int'(wraps), e_wraps);
      check({tag, ".run_cycles"}, n_run, e_run);
      check({tag, ".ce_cycles"}, n_ce, e_ce);
      check({tag, ".ce_outside_run"}, ce_out, 0);
      check({tag, ".q_frozen_bad"}, frz_bad, 0);
      check({tag, ".err"}, int'(err), 0);
      if (e_done == 1 && l > 0) check({tag, ".q_end"}, q_end, 0);
   endtask

   task automatic all_zero(input string tag);
      check({tag, ".cnt_ce"}, int'(cnt_ce), 0);
      check({tag, ".cnt_r"}, int'(cnt_r), 0);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".done"}, int'(done), 0);
      check({tag, ".wraps"}, int'(wraps), 0);
      check({tag, ".err"}, int'(err), 0);
   endtask

   initial begin
      int d, w, r, c, l, ab;
      tbl[0] = '{2, 0, 0, -1, 1, 2, 32, 32};
      tbl[1] = '{0, 0, 0, -1, 1, 0, 0, 0};
      tbl[2] = '{1, 6, 5, -1, 1, 1, 21, 16};
      tbl[3] = '{3, 0, 0, 20, 0, 1, 21, 20};
      tbl[4] = '{1, 0, 0, 0, 0, 0, 1, 0};
      tbl[5] = '{1, 0, 0, 15, 0, 0, 16, 15};

      // Reset state
      repeat (2) @(negedge clk);
      all_zero("reset");
      R_n = 1'b1;
      @(negedge clk);

      // len=0 with start held through DONE: one done, then IDLE
      start = 1'b1; len = '0;
      @(negedge clk);
      check("len0.done", int'(done), 1);
      check("len0.cnt_ce", int'(cnt_ce), 0);
      @(negedge clk);
      start = 1'b0;
      check("len0.done_ignored_start", int'(done), 0);
      check("len0.busy_ignored_start", int'(busy), 0);
      check("len0.wraps", int'(wraps), 0);
      @(negedge clk);

      // 2-bit jump during RUN sets a sticky err
      start = 1'b1; len = LW'(3);
      @(negedge clk);
      start = 1'b0;
      check("inj.cnt_r", int'(cnt_r), 1);
      check("inj.ce_in_clr", int'(cnt_ce), 0);
      repeat (10) @(negedge clk);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      check("inj.err_before_edge", int'(err), 0);
      @(negedge clk);
      check("inj.err_set", int'(err), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("inj.abort_busy", int'(busy), 0);
      check("inj.abort_done", int'(done), 0);
      repeat (3) @(negedge clk);
      check("inj.err_sticky", int'(err), 1);

      // Start clears err; uncleared counter in first RUN cycle sets it; mid-run reset
      start = 1'b1; len = LW'(2); hold_clr = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first.err_cleared_by_start", int'(err), 0);
      @(negedge clk);
      hold_clr = 1'b0;
      @(negedge clk);
      check("first.err_nonzero_start", int'(err), 1);
      repeat (3) @(negedge clk);
      check("midrst.wraps_before", int'(wraps), 1);
      check("midrst.busy_before", int'(busy), 1);
      R_n = 1'b0;
      #1;
      all_zero("midrst");
      @(negedge clk);
      R_n = 1'b1;
      @(negedge clk);

      // Table-driven runs
      foreach (tbl[i]) begin
         for (int k = 0; k < 512; k++)
            pat[k] = (k >= tbl[i].ps) && (k < tbl[i].ps + tbl[i].pl);
         run_one($sformatf("tbl%0d", i), tbl[i].len, tbl[i].ab, 1'b0,
                 tbl[i].e_done, tbl[i].e_wraps, tbl[i].e_run, tbl[i].e_ce);
      end

      // Abort during CLR
      for (int k = 0; k < 512; k++) pat[k] = 1'b0;
      run_one("clr_abort", 2, -2, 1'b0, 0, 0, 0, 0);

      // Randomized runs against the model
      for (int t = 0; t < 20; t++) begin
         l = $urandom_range(0, 3);
         case ($urandom_range(0, 3))
            0:       ab = -2;
            1:       ab = $urandom_range(0, 16 * l + 8);
            default: ab = -1;
         endcase
         for (int k = 0; k < 512; k++) pat[k] = ($urandom_range(0, 3) == 0);
         model(l, ab, d, w, r, c);
         run_one($sformatf("rnd%0d", t), l, ab, 1'b1, d, w, r, c);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_run_ctrl.md
GRAY_RUN_CTRL -- requirements
Module: gray_run_ctrl

Interface
REQ-001 Parameter W, default 4, width of the controlled Gray counter.
REQ-002 Parameter LW, default 8, width of the run-length and wrap-count fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 R_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a run; sampled only in IDLE.
REQ-006 len  input  LW  number of full counter periods (TC wraps) to run; sampled with start.
REQ-007 pause  input  1  holds the counter (cnt_ce low) while in RUN.
REQ-008 abort  input  1  terminates a run without done.
REQ-009 cnt_q  input  W  Gray counter output.
REQ-010 cnt_ceo  input  1  counter carry-enable out (ce AND TC).
REQ-011 cnt_ce  output  1  clock enable to the counter.
REQ-012 cnt_r  output  1  synchronous clear to the counter, active-high.
REQ-013 busy  output  1  high in CLR and RUN.
REQ-014 done  output  1  one-cycle pulse at normal run completion.
REQ-015 wraps  output  LW  periods completed in the current/last run.
REQ-016 err  output  1  sticky Gray-sequence violation flag.

Function
REQ-017 FSM states IDLE, CLR, RUN, DONE; exactly one active.
REQ-018 IDLE: start=1 and len!=0 -> CLR; len latched into len_r; wraps and err cleared.
REQ-019 IDLE: start=1 and len==0 -> DONE; counter never enabled; wraps stays 0.
REQ-020 CLR lasts exactly one cycle: cnt_r=1, cnt_ce=0; then RUN.
REQ-021 cnt_ce = (state==RUN) AND NOT pause AND NOT abort, combinational; cnt_r=1 only in CLR.
REQ-022 RUN: each cycle with cnt_ceo=1 increments wraps, saturating at 2^LW-1.
REQ-023 RUN: cnt_ceo=1 with wraps+1==len_r -> DONE next cycle; counter's final step (wrap to 0) occurs on that same edge.
REQ-024 DONE lasts one cycle with done=1, then IDLE; start during DONE ignored.
REQ-025 start ignored whenever state != IDLE.
REQ-026 abort=1 in CLR or RUN -> IDLE next cycle, done not pulsed, wraps holds its value; abort has priority over cnt_ceo completion.
REQ-027 pause has no effect outside RUN; pause during the completing cnt_ceo cycle is impossible because cnt_ce is then 0 (no cnt_ceo).
REQ-028 Gray checker: registers cnt_q and the previous cycle's cnt_ce; when previous cnt_ce=1 and popcount(cnt_q XOR prev_q) != 1, err is set.
REQ-029 Checker also sets err if cnt_q != 0 in the first RUN cycle after CLR.
REQ-030 err is cleared only by reset or by an accepted start.
REQ-031 Checker is inactive in IDLE, CLR, and DONE except REQ-029.

Reset
REQ-032 R_n low asynchronously forces state=IDLE, cnt_ce=0, cnt_r=0, busy=0, done=0, wraps=0, err=0, len_r=0, checker registers=0.
REQ-033 Reset deassertion is used as is; first active edge after R_n rises evaluates IDLE.
REQ-034 Reset mid-run abandons the run with no done pulse.

Structure
REQ-035 Shared package gray_ctrl_pkg holds the state encoding (2-bit localparams) and the Gray TC constant function (MSB=1, others 0 for width W).
REQ-036 Sub-module gray_step_chk (W-bit popcount-of-XOR checker, registered prev_q/prev_ce) instantiated once; FSM and wrap counter stay in gray_run_ctrl.

Verification
REQ-037 Bench instantiates gray_run_ctrl with a behavioural W=4 Gray counter driven by cnt_ce/cnt_r.
REQ-038 Reset, start with len=2 -> CLR 1 cycle, 32 enabled cycles, wraps=2, done pulses once, cnt_q=0 at end.
REQ-039 start with len=0 -> done on next cycle, cnt_ce never high, wraps=0.
REQ-040 len=1 with pause high 5 cycles mid-run -> run takes 16+5 RUN cycles, cnt_q frozen while paused, done once.
REQ-041 len=3, abort after 20 RUN cycles -> IDLE next cycle, no done, wraps=1, cnt_ce low.
REQ-042 Inject a 2-bit jump in cnt_q during RUN -> err=1 next cycle, stays 1 until next start; R_n low mid-run -> all outputs 0 immediately.
